// File: rtl/fp_issue_scheduler.sv
// Round-robin issue arbiter sharing the FP and integer pipelines, with a writeback-slot
// reservation shift register. Optional perf counters are built when FP_ISSUE_STATS_EN is defined.
module fp_issue_scheduler #(
  parameter int unsigned THREADS    = 4,
  parameter int unsigned FP_LATENCY = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [THREADS-1:0]         ts_request,
  input  logic [THREADS-1:0]         ts_is_fp,
  input  logic                       ix_stall,
  output logic [THREADS-1:0]         fis_grant_oh,
  output logic                       fis_issue_valid,
  output logic                       fis_issue_is_fp,
  output logic [$clog2(THREADS)-1:0] fis_grant_idx,
  output logic [31:0]                perf_fp_issue,
  output logic [31:0]                perf_wb_conflict
);

  localparam int unsigned IDX_W  = $clog2(THREADS);
  localparam int unsigned SLOT_W = FP_LATENCY - 1;
  localparam int unsigned CNT_W  = 32;

  logic [SLOT_W-1:0]  wb_slot_q, wb_slot_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [THREADS-1:0] eligible;
  logic [THREADS-1:0] grant_oh_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               found;
  logic               issue_fp;
  int unsigned        cand;
  logic [IDX_W-1:0]   cand_idx;

  // Integer requests are masked when an FP writeback already owns the next cycle.
  assign eligible = ts_request & (ts_is_fp | {THREADS{~wb_slot_q[0]}}) & {THREADS{~ix_stall}};

  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned off = 1; off <= THREADS; off++) begin
      cand     = (32'(last_grant_q) + off) % THREADS;
      cand_idx = IDX_W'(cand);
      if (!found && eligible[cand_idx]) begin
        found                = 1'b1;
        grant_idx_c          = cand_idx;
        grant_oh_c[cand_idx] = 1'b1;
      end
    end
  end

  assign fis_grant_oh    = grant_oh_c;
  assign fis_issue_valid = |grant_oh_c;
  assign fis_issue_is_fp = |(grant_oh_c & ts_is_fp);
  assign fis_grant_idx   = grant_idx_c;
  assign issue_fp        = fis_issue_is_fp;

  always_comb begin
    wb_slot_d = '0;
    for (int unsigned k = 0; k + 1 < SLOT_W; k++) begin
      wb_slot_d[k] = wb_slot_q[k+1];
    end
    wb_slot_d[SLOT_W-1] = issue_fp;
    last_grant_d        = fis_issue_valid ? grant_idx_c : last_grant_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_slot_q    <= '0;
      last_grant_q <= IDX_W'(THREADS - 1);
    end else begin
      wb_slot_q    <= wb_slot_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef FP_ISSUE_STATS_EN
  logic [CNT_W-1:0] fp_cnt_q, fp_cnt_d;
  logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;
  logic             conflict_c;

  // A conflict cycle is any unstalled cycle where some integer requester sees the slot taken.
  assign conflict_c = !ix_stall && wb_slot_q[0] && (|(ts_request & ~ts_is_fp));

  always_comb begin
    fp_cnt_d   = fp_cnt_q + CNT_W'(issue_fp);
    conf_cnt_d = conf_cnt_q + CNT_W'(conflict_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fp_cnt_q   <= '0;
      conf_cnt_q <= '0;
    end else begin
      fp_cnt_q   <= fp_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign perf_fp_issue    = fp_cnt_q;
  assign perf_wb_conflict = conf_cnt_q;
`else
  assign perf_fp_issue    = '0;
  assign perf_wb_conflict = '0;
`endif

endmodule

// File: doc/fp_issue_scheduler.md
# fp_issue_scheduler

Per-cycle issue arbiter for one core. Shares the floating point pipeline and the single-cycle integer pipeline among hardware threads, round-robin. Integer (latency 1) and floating point (latency FP_LATENCY) results share one writeback port. A writeback-slot reservation shift register stops an integer instruction from issuing in a cycle where it would collide at writeback with an earlier floating point instruction. Sits between thread select and the execute stages.

## Interface
- THREADS, 4, number of requesting threads (≥2)
- FP_LATENCY, 5, issue-to-writeback cycles of the floating point pipeline (≥2)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- ts_request  in  THREADS  thread i has an instruction ready to issue
- ts_is_fp  in  THREADS  thread i's instruction targets the floating point pipeline; otherwise the integer pipeline
- ix_stall  in  1  downstream cannot accept an instruction this cycle
- fis_grant_oh  out  THREADS  one-hot grant; all zero when nothing issues
- fis_issue_valid  out  1  an instruction issues this cycle (OR of fis_grant_oh)
- fis_issue_is_fp  out  1  granted instruction targets the FP pipeline; 0 when not valid
- fis_grant_idx  out  $clog2(THREADS)  index of the granted thread; 0 when not valid
- perf_fp_issue  out  32  FP issues counted (see Configuration)
- perf_wb_conflict  out  32  writeback-conflict stall cycles (see Configuration)

## Operation
- State:
  - wb_slot[FP_LATENCY-2:0]: wb_slot[k] set means a writeback is reserved k+1 cycles after the current cycle.
  - last_grant: index of the most recently granted thread.
- Eligibility: eligible[i] = ts_request[i] && !ix_stall && (ts_is_fp[i] || !wb_slot[0]).
- Arbitration: the first eligible thread, searching circularly from last_grant+1, is granted. At most one grant per cycle.
- Slot update every cycle, including stall cycles:
  - wb_slot_next[k] = wb_slot[k+1]
  - wb_slot_next[FP_LATENCY-2] = 0
  - Then, if an FP instruction issues, wb_slot_next[FP_LATENCY-2] = 1.
- FP never collides with FP, because only one instruction issues per cycle.
- An integer instruction issued at t writes back at t+1. It collides only with an FP instruction issued at t+1-FP_LATENCY, which is what wb_slot[0] holds.
- last_grant updates to the granted index on issue. It holds when nothing issues.
- Requests that are not granted are not latched. The requester keeps ts_request asserted until it sees its grant.
- A blocked integer thread does not block lower-priority eligible threads. They are granted in its place.
- Reset values: wb_slot = 0; last_grant = THREADS-1, so thread 0 has first priority; perf counters = 0.
- Reset mid-operation discards all reservations. The downstream is flushed by the same reset.

## Timing
- Grant outputs are combinational from registered state and the current inputs. Issue latency is 0 cycles from request to grant.
- State updates on the clk rising edge. Reset acts immediately, with no clock required.
- ix_stall forces every grant output to 0 in the same cycle. Slots still shift during the stall.
- ts_request deasserted in the same cycle means no grant for that thread.
- Boundary cases:
  - All threads integer with wb_slot[0]=1: no issue that cycle.
  - All threads FP: never blocked by slots.
  - last_grant = THREADS-1: the search wraps to 0.
- Counters wrap modulo 2^32 with no saturation.

## Configuration
- FP_ISSUE_STATS_EN defined:
  - perf_fp_issue increments in each cycle where fis_issue_valid && fis_issue_is_fp.
  - perf_wb_conflict increments in each cycle where !ix_stall and some i has ts_request[i] && !ts_is_fp[i] && wb_slot[0].
- FP_ISSUE_STATS_EN undefined: no counter flops are built, and both perf outputs are constant 0.

## Test plan
- Reset, then ts_request=4'b1111 with all integer and no stall, held 5 cycles -> grants 0,1,2,3,0.
- Thread 0 FP at cycle 0, then thread 1 integer only, requesting from cycle 1 -> no grant at cycle 4 (wb_slot[0] set), grant at cycles 1-3 and 5. With stats, perf_wb_conflict=1 and perf_fp_issue=1.
- Cycle 4 of the previous case, but thread 2 also requests FP -> thread 2 granted at cycle 4 while thread 1 is blocked.
- FP issue, then ix_stall held 3 cycles, then an integer request at cycle FP_LATENCY-1 -> blocked at exactly cycle 4 and granted at 5. The stall does not delay expiry of the reservation.
- FP issue every cycle for 10 cycles, plus a persistent integer request -> the integer request is never granted from cycle 4 on, while FP issues continue; on removing the FP requests the integer request is granted after 4 more cycles.
- Assert reset at cycle 2 after an FP issue at cycle 1, then deassert -> wb_slot cleared, integer request granted on the first cycle after reset, last_grant=THREADS-1, counters 0.
